// File: rtl/fan_ctrl.sv
// Multi-channel Wishbone fan controller: per-channel PWM drive and filtered tach edge counting.
// Define FAN_STALL_IRQ_EN to build the stall detector with its STAT/MASK/THRESH registers and IRQ.
module fan_ctrl #(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned PWM_W    = 10,
  parameter int unsigned CNT_W    = 27,
  parameter int unsigned WIN_CNT  = 50000000 - 1,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              FAN_STB_I,
  input  logic              FAN_WE_I,
  input  logic [5:0]        FAN_ADR_I,
  input  logic [31:0]       FAN_DAT_I,
  output logic              FAN_ACK_O,
  output logic [31:0]       FAN_DAT_O,
  output logic [CH_NUM-1:0] FAN_PWM_O,
  input  logic [CH_NUM-1:0] FAN_TACH_I,
  output logic              FAN_IRQ_O
);

  localparam int unsigned WIN_W = (WIN_CNT == 0) ? 1 : $clog2(WIN_CNT + 1);

  localparam logic [3:0] WordCtrl   = 4'd8;
  localparam logic [3:0] WordStat   = 4'd9;
  localparam logic [3:0] WordMask   = 4'd10;
  localparam logic [3:0] WordThresh = 4'd11;

  logic              ack_q;
  logic [31:0]       dat_q;
  logic [PWM_W-1:0]  duty_q [CH_NUM];
  logic [CNT_W-1:0]  tach_q [CH_NUM];
  logic [CNT_W-1:0]  chan_q [CH_NUM];
  logic [CNT_W-1:0]  chan_nxt [CH_NUM];
  logic [3:0]        filt_cnt_q [CH_NUM];
  logic [CH_NUM-1:0] ctrl_q;
  logic [CH_NUM-1:0] pwm_q;
  logic [CH_NUM-1:0] sync1_q, sync2_q, filt_lvl_q;
  logic [CH_NUM-1:0] differ, accept, fall;
  logic [PWM_W-1:0]  pwm_cnt_q;
  logic [WIN_W-1:0]  win_q;
  logic              win_end;
  logic [CH_NUM-1:0] stat_q, mask_q;
  logic [CNT_W-1:0]  thresh_q;
  logic              acc, wr;
  logic [3:0]        word;
  logic              aligned;
  logic [31:0]       rdata;
  logic              unused_dat;

  assign acc     = FAN_STB_I & ~ack_q;
  assign wr      = acc & FAN_WE_I;
  assign word    = FAN_ADR_I[5:2];
  assign aligned = (FAN_ADR_I[1:0] == 2'b00);
  assign win_end = (win_q == WIN_W'(WIN_CNT));
  assign unused_dat = ^FAN_DAT_I;

  // A level change is accepted on the FILT_LEN-th consecutive differing sample.
  always_comb begin
    differ = '0;
    accept = '0;
    fall   = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      differ[n]   = sync2_q[n] ^ filt_lvl_q[n];
      accept[n]   = differ[n] & (filt_cnt_q[n] == 4'(FILT_LEN - 1));
      fall[n]     = accept[n] & ~sync2_q[n];
      chan_nxt[n] = chan_q[n];
      if (fall[n] && (chan_q[n] != {CNT_W{1'b1}})) chan_nxt[n] = chan_q[n] + CNT_W'(1);
    end
  end

  always_comb begin
    rdata = '0;
    if (aligned) begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (word == 4'(n))     rdata = 32'(duty_q[n]);
        if (word == 4'(n + 4)) rdata = 32'(tach_q[n]);
      end
      if (word == WordCtrl)   rdata = 32'(ctrl_q);
      if (word == WordStat)   rdata = 32'(stat_q);
      if (word == WordMask)   rdata = 32'(mask_q);
      if (word == WordThresh) rdata = 32'(thresh_q);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      ctrl_q     <= '0;
      pwm_q      <= '0;
      pwm_cnt_q  <= '0;
      win_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_lvl_q <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        duty_q[n]     <= '0;
        tach_q[n]     <= '0;
        chan_q[n]     <= '0;
        filt_cnt_q[n] <= '0;
      end
    end else begin
      ack_q     <= acc;
      dat_q     <= (acc && !FAN_WE_I) ? rdata : 32'd0;
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      win_q     <= win_end ? '0 : win_q + WIN_W'(1);
      sync1_q   <= FAN_TACH_I;
      sync2_q   <= sync1_q;
      if (wr && aligned && word == WordCtrl) ctrl_q <= FAN_DAT_I[CH_NUM-1:0];
      for (int n = 0; n < CH_NUM; n++) begin
        if (wr && aligned && word == 4'(n)) duty_q[n] <= FAN_DAT_I[PWM_W-1:0];
        pwm_q[n] <= ctrl_q[n] & ((duty_q[n] == {PWM_W{1'b1}}) | (pwm_cnt_q < duty_q[n]));
        if (!differ[n]) begin
          filt_cnt_q[n] <= '0;
        end else if (accept[n]) begin
          filt_lvl_q[n] <= sync2_q[n];
          filt_cnt_q[n] <= '0;
        end else begin
          filt_cnt_q[n] <= filt_cnt_q[n] + 4'd1;
        end
        // An edge on the terminal cycle still belongs to the closing window.
        if (win_end) begin
          tach_q[n] <= chan_nxt[n];
          chan_q[n] <= '0;
        end else begin
          chan_q[n] <= chan_nxt[n];
        end
      end
    end
  end

`ifdef FAN_STALL_IRQ_EN
  logic              irq_q;
  logic [CH_NUM-1:0] stall_set;
  logic [CH_NUM-1:0] stat_d;

  always_comb begin
    stall_set = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      stall_set[n] = win_end & ctrl_q[n] & (duty_q[n] != '0) & (chan_nxt[n] < thresh_q);
    end
    stat_d = stat_q;
    if (wr && aligned && word == WordStat) stat_d = stat_d & ~FAN_DAT_I[CH_NUM-1:0];
    stat_d = stat_d | stall_set;  // a new stall beats a simultaneous clear
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      stat_q   <= '0;
      mask_q   <= '0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      stat_q <= stat_d;
      irq_q  <= |(stat_q & mask_q);
      if (wr && aligned && word == WordMask)   mask_q   <= FAN_DAT_I[CH_NUM-1:0];
      if (wr && aligned && word == WordThresh) thresh_q <= FAN_DAT_I[CNT_W-1:0];
    end
  end

  assign FAN_IRQ_O = irq_q;
`else
  assign stat_q    = '0;
  assign mask_q    = '0;
  assign thresh_q  = '0;
  assign FAN_IRQ_O = 1'b0;
`endif

  assign FAN_ACK_O = ack_q;
  assign FAN_DAT_O = dat_q;
  assign FAN_PWM_O = pwm_q;

endmodule

// File: tb/tb_fan_ctrl.sv
// Directed bench for fan_ctrl (2 channels, 4-bit PWM, 100-cycle window, 3-sample tach filter).
// Stall checks run when FAN_STALL_IRQ_EN is defined; otherwise the stall registers must read 0.
module tb_fan_ctrl;

  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stb = 1'b0;
  logic          we  = 1'b0;
  logic [5:0]    adr = '0;
  logic [31:0]   wdat = '0;
  logic          ack;
  logic [31:0]   rdat;
  logic [CH-1:0] pwm;
  logic [CH-1:0] tach = '0;
  logic          irq;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  fan_ctrl #(
    .CH_NUM  (CH),
    .PWM_W   (4),
    .CNT_W   (8),
    .WIN_CNT (99),
    .FILT_LEN(3)
  ) dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .FAN_STB_I (stb),
    .FAN_WE_I  (we),
    .FAN_ADR_I (adr),
    .FAN_DAT_I (wdat),
    .FAN_ACK_O (ack),
    .FAN_DAT_O (rdat),
    .FAN_PWM_O (pwm),
    .FAN_TACH_I(tach),
    .FAN_IRQ_O (irq)
  );

  always #5 clk = ~clk;

  // cyc = number of posedges since the reset edge; k-th posedge after release is "Pk".
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Leave the caller at the negedge just before posedge Pk.
  task automatic goto_cyc(input int k);
    int budget = 0;
    while (cyc < k - 1 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (cyc != k - 1) begin
      failures++;
      $display("FAIL schedule: at cycle %0d expected %0d", cyc, k - 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tach = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    stb = 1'b1; we = 1'b0; adr = a;
    @(negedge clk);
    d = rdat;
    stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_high(output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
    end
  endtask

  // Period-8 pulses on tach[0]; each fall counts 4 posedges after it is driven.
  task automatic pulse_train(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      goto_cyc(start + 8 * i);
      tach[0] = 1'b1;
      goto_cyc(start + 8 * i + 4);
      tach[0] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int h0, h1;

    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_dat", rdat, 32'd0);
    check_eq("rst_pwm", 32'(pwm), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    bus_read(6'h00, d); check_eq("rst_duty0", d, 32'd0);
    bus_read(6'h04, d); check_eq("rst_duty1", d, 32'd0);
    bus_read(6'h10, d); check_eq("rst_tach0", d, 32'd0);
    bus_read(6'h20, d); check_eq("rst_ctrl", d, 32'd0);
    bus_read(6'h2C, d); check_eq("rst_thresh", d, 32'd0);

    // PWM duty patterns
    bus_write(6'h20, 32'h3);
    bus_write(6'h00, 32'hFFFF_FF04);
    bus_write(6'h04, 32'hF);
    bus_read(6'h00, d); check_eq("duty0_rb", d, 32'h4);
    bus_read(6'h20, d); check_eq("ctrl_rb", d, 32'h3);
    count_high(h0, h1);
    check_eq("pwm0_duty4", 32'(h0), 32'd4);
    check_eq("pwm1_full", 32'(h1), 32'd16);
    bus_write(6'h00, 32'h0);
    @(negedge clk);
    count_high(h0, h1);
    check_eq("pwm0_duty0", 32'(h0), 32'd0);
    check_eq("pwm1_still", 32'(h1), 32'd16);

    // Held strobe: one access per two cycles
    stb = 1'b1; we = 1'b0; adr = 6'h20;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("held_ack", 32'(ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq("held_dat", rdat, (i % 2 == 0) ? 32'd3 : 32'd0);
    end
    stb = 1'b0;
    @(negedge clk);

    // Unmapped addresses and channels beyond CH_NUM
    bus_write(6'h30, 32'hFFFF);
    bus_write(6'h0C, 32'h5);
    bus_read(6'h30, d); check_eq("unmapped_30", d, 32'd0);
    bus_read(6'h0C, d); check_eq("duty3_absent", d, 32'd0);
    bus_read(6'h1C, d); check_eq("tach3_absent", d, 32'd0);

`ifndef FAN_STALL_IRQ_EN
    bus_write(6'h24, 32'hFF);
    bus_write(6'h28, 32'hFF);
    bus_write(6'h2C, 32'hFF);
    bus_read(6'h24, d); check_eq("nostall_stat", d, 32'd0);
    bus_read(6'h28, d); check_eq("nostall_mask", d, 32'd0);
    bus_read(6'h2C, d); check_eq("nostall_thresh", d, 32'd0);
    check_eq("nostall_irq", 32'(irq), 32'd0);
`endif

    // Tach counting: 10 clean pulses plus 1- and 2-cycle glitches in window 0
    do_reset();
    pulse_train(1, 10);
    goto_cyc(85); tach[0] = 1'b1;
    goto_cyc(86); tach[0] = 1'b0;
    goto_cyc(89); tach[0] = 1'b1;
    goto_cyc(91); tach[0] = 1'b0;
    goto_cyc(95);
    bus_read(6'h10, d); check_eq("tach0_midwin", d, 32'd0);
    goto_cyc(101);
    bus_read(6'h10, d); check_eq("tach0_10", d, 32'd10);
    bus_read(6'h14, d); check_eq("tach1_idle", d, 32'd0);

    // Fall counted exactly on the terminal cycle (P200) stays in window 1
    goto_cyc(190); tach[0] = 1'b1;
    goto_cyc(196); tach[0] = 1'b0;
    goto_cyc(201);
    bus_read(6'h10, d); check_eq("tach0_term", d, 32'd1);
    goto_cyc(240); tach[0] = 1'b1;
    goto_cyc(246); tach[0] = 1'b0;
    goto_cyc(301);
    bus_read(6'h10, d); check_eq("tach0_next", d, 32'd1);

    // Reset mid-window discards partial counts; first window after reset is full length
    goto_cyc(310); tach[0] = 1'b1;
    goto_cyc(314); tach[0] = 1'b0;
    goto_cyc(330);
    do_reset();
    goto_cyc(90); tach[0] = 1'b1;
    goto_cyc(96); tach[0] = 1'b0;
    goto_cyc(101);
    bus_read(6'h10, d); check_eq("tach0_postrst", d, 32'd1);

`ifdef FAN_STALL_IRQ_EN
    do_reset();
    bus_write(6'h20, 32'h1);
    bus_write(6'h00, 32'h8);
    bus_write(6'h2C, 32'h5);
    bus_write(6'h28, 32'h1);
    pulse_train(20, 3);
    goto_cyc(102);
    bus_read(6'h24, d); check_eq("stall_stat", d, 32'h1);
    check_eq("stall_irq", 32'(irq), 32'd1);
    pulse_train(120, 3);
    goto_cyc(200);
    bus_write(6'h24, 32'h1);
    bus_read(6'h24, d); check_eq("set_beats_clr", d, 32'h1);
    pulse_train(210, 8);
    goto_cyc(305);
    check_eq("irq_before_clr", 32'(irq), 32'd1);
    bus_write(6'h24, 32'h1);
    check_eq("irq_cleared", 32'(irq), 32'd0);
    bus_read(6'h24, d); check_eq("stat_cleared", d, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fan_ctrl.md
# fan_ctrl

Parametrised multi-channel fan controller on the Wishbone peripheral bus: CH_NUM independent PWM outputs, CH_NUM tachometer inputs with synchronisation, glitch filtering and per-window edge counting, plus optional stall detection with a maskable interrupt. It is the next-generation replacement for the single PWM and fixed two-fan speed logic in the system peripheral block. It sits beside the other Wishbone slaves and drives fan headers directly.

## Interface
- CH_NUM, 4, number of fan channels (1..4)
- PWM_W, 10, PWM counter/duty width in bits (4..16)
- CNT_W, 27, tach counter/threshold width in bits (1..32)
- WIN_CNT, 50000000-1, measurement window terminal count (window = WIN_CNT+1 cycles)
- FILT_LEN, 3, consecutive equal synchronised samples required to accept a tach level (1..8)

- CLK_I  in  1  system clock; one clock domain
- RST_I  in  1  reset, synchronous, active-high
- FAN_STB_I  in  1  Wishbone strobe
- FAN_WE_I  in  1  Wishbone write enable
- FAN_ADR_I  in  6  byte address
- FAN_DAT_I  in  32  write data
- FAN_ACK_O  out  1  Wishbone acknowledge
- FAN_DAT_O  out  32  read data
- FAN_PWM_O  out  CH_NUM  PWM drive, one bit per channel
- FAN_TACH_I  in  CH_NUM  asynchronous tach inputs
- FAN_IRQ_O  out  1  stall interrupt, level

## Operation
- Register map (unmapped or n>=CH_NUM: read 0, write ignored; FAN_DAT_I bits above field width ignored):
  - 0x00+4n DUTY[n] RW [PWM_W-1:0], reset 0
  - 0x10+4n TACH[n] RO [CNT_W-1:0], falling edges in last completed window, reset 0
  - 0x20 CTRL RW [CH_NUM-1:0] channel enable, reset 0
  - 0x24 STAT W1C [CH_NUM-1:0] sticky stall flags, reset 0
  - 0x28 MASK RW [CH_NUM-1:0] interrupt enable, reset 0
  - 0x2C THRESH RW [CNT_W-1:0] stall threshold, reset 0
- Bus: FAN_ACK_O <= FAN_STB_I & ~FAN_ACK_O; write/read accepted only when FAN_STB_I & ~FAN_ACK_O. FAN_DAT_O registered, valid in the ACK cycle, 0 otherwise.
- PWM: one shared free-running PWM_W-bit counter, wraps at all-ones. FAN_PWM_O[n] = CTRL[n] & (DUTY[n]=all-ones | pwm_cnt < DUTY[n]), registered. DUTY 0 -> constant low; all-ones -> constant high.
- Tach: 2-flop synchroniser, then filter: accepted level changes only after FILT_LEN consecutive equal samples. Falling edge of accepted level increments channel counter; counter saturates at all-ones.
- Window: counter 0..WIN_CNT; at WIN_CNT, TACH[n] <= channel counter (including an edge that same cycle), channel counter <= 0.
- Stall (see Configuration): at window end, for each n with CTRL[n]=1 and DUTY[n]!=0, new TACH[n] < THRESH sets STAT[n]. Set wins over a simultaneous W1C clear. FAN_IRQ_O = |(STAT & MASK), registered.

## Timing
- Reset: FAN_ACK_O=0, FAN_DAT_O=0, FAN_PWM_O=0, FAN_IRQ_O=0; all registers, PWM counter, window counter, filters, channel counters cleared.
- Write takes effect at the edge that raises ACK; PWM output reflects new DUTY/CTRL one cycle later.
- Tach latency: input edge to counter increment = 2 (sync) + FILT_LEN cycles.
- TACH/STAT update on the cycle after window terminal count; FAN_IRQ_O one cycle after STAT.
- Back-to-back STB held high: ACK toggles, one access per two cycles.
- Reset mid-window discards partial counts; first window after reset is full length.

## Configuration
- FAN_STALL_IRQ_EN defined: stall detection, STAT, MASK, THRESH and FAN_IRQ_O as above.
- Not defined: no stall logic; STAT/MASK/THRESH read 0, writes ignored; FAN_IRQ_O tied 0. PWM and tach unaffected.

## Test plan
- Params CH_NUM=2, PWM_W=4, WIN_CNT=99, FILT_LEN=3. Reset -> all outputs 0, all reads 0.
- CTRL=0x3, DUTY[0]=4, DUTY[1]=0xF -> ch0 high 4 of every 16 cycles; ch1 constant high; DUTY[0]=0 -> ch0 constant low.
- Tach 0: 10 clean pulses (period 8) in one window -> TACH[0]=10 after window end; 1-cycle and 2-cycle glitches -> not counted.
- Edge landing on window terminal cycle -> counted in closing window, next window starts at 0.
- FAN_STALL_IRQ_EN: THRESH=5, MASK=0x1, ch0 enabled, 3 pulses/window -> STAT=0x1, FAN_IRQ_O=1; W1C 0x1 on set cycle -> STAT stays 1; W1C later with tach 8 pulses -> IRQ 0.
- Read of 0x30 and TACH[3] with CH_NUM=2 -> 0; ACK single-cycle per access under held STB.
